// File: rtl/mem_port_arbiter_if.sv
// Purpose : bundle of the requester (IF/DM), memory-macro and status signals
//           seen by mem_port_arbiter.
// Modports: slave  - arbiter side (takes requests and mem_rdata, drives acks,
//                    read data, mem_* controls and status)
//           master - pipeline/memory side (the mirror image)
interface mem_port_arbiter_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 32
);
   // fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [WIDTH-1:0]  if_rdata;
   // data port
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [WIDTH-1:0]  dm_wdata;
   logic              dm_ack;
   logic [WIDTH-1:0]  dm_rdata;
   // memory macro
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_wdata;
   logic [WIDTH-1:0]  mem_rdata;
   // status for hazard logic
   logic              stall_f;
   logic              stall_m;
   logic              busy;
   logic              owner;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output stall_f, stall_m, busy, owner
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  stall_f, stall_m, busy, owner
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port, fixed-latency memory between the fetch
//          (IF) and data (DM) ports. DM has priority except that IF is granted
//          after two consecutive DM grants taken while IF was waiting.
// Ports  : clk   - rising-edge clock
//          reset - synchronous, active-low reset
//          bus   - mem_port_arbiter_if.slave: IF/DM request-ack ports,
//                  mem_* macro controls, stall_f/stall_m, busy, owner
module mem_port_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MEM_LAT - 1);
   localparam logic [1:0]       STARVE_LIM = 2'd2;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

   state_t            r_state,     w_state;
   logic [CNT_W-1:0]  r_cnt,       w_cnt;
   logic [1:0]        r_starve,    w_starve;
   logic              r_owner,     w_owner;
   logic              r_mem_en,    w_mem_en;
   logic              r_mem_we,    w_mem_we;
   logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr;
   logic [WIDTH-1:0]  r_mem_wdata, w_mem_wdata;
   logic              r_if_ack,    w_if_ack;
   logic              r_dm_ack,    w_dm_ack;
   logic [WIDTH-1:0]  r_if_rdata,  w_if_rdata;
   logic [WIDTH-1:0]  r_dm_rdata,  w_dm_rdata;
   logic              w_grant_dm;

   // DM wins unless IF is waiting and has already been passed over twice
   assign w_grant_dm = bus.dm_req && ((r_starve < STARVE_LIM) || !bus.if_req);

   // state and output registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_starve    <= '0;
         r_owner     <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_ack    <= 1'b0;
         r_dm_ack    <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_starve    <= w_starve;
         r_owner     <= w_owner;
         r_mem_en    <= w_mem_en;
         r_mem_we    <= w_mem_we;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_if_ack    <= w_if_ack;
         r_dm_ack    <= w_dm_ack;
         r_if_rdata  <= w_if_rdata;
         r_dm_rdata  <= w_dm_rdata;
      end
   end

   // next state; mem_en/mem_we/acks are computed one cycle ahead so the
   // registered outputs line up with ACCESS and RESP
   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_starve    = r_starve;
      w_owner     = r_owner;
      w_mem_en    = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      w_if_ack    = 1'b0;
      w_dm_ack    = 1'b0;
      w_if_rdata  = r_if_rdata;
      w_dm_rdata  = r_dm_rdata;

      unique case (r_state)
         ST_IDLE: begin
            if (bus.if_req || bus.dm_req) begin
               w_state  = ST_ACCESS;
               w_cnt    = '0;
               w_owner  = w_grant_dm;
               w_mem_en = 1'b1;
               if (w_grant_dm) begin
                  w_mem_we    = bus.dm_we;
                  w_mem_addr  = bus.dm_addr;
                  w_mem_wdata = bus.dm_wdata;
                  // saturating count of DM grants taken over a waiting IF
                  if (bus.if_req)
                     w_starve = (r_starve == 2'd3) ? r_starve : r_starve + 2'd1;
                  else
                     w_starve = '0;
               end else begin
                  w_mem_we   = 1'b0;
                  w_mem_addr = bus.if_addr;
                  w_starve   = '0;
               end
            end
         end

         ST_ACCESS: begin
            w_cnt    = r_cnt + CNT_W'(1);
            w_mem_en = 1'b1;
            w_mem_we = r_mem_we;
            if (r_cnt == CNT_LAST) begin
               w_state  = ST_RESP;
               w_mem_en = 1'b0;
               w_mem_we = 1'b0;
               if (r_owner) begin
                  w_dm_ack = 1'b1;
                  if (!r_mem_we)
                     w_dm_rdata = bus.mem_rdata;
               end else begin
                  w_if_ack   = 1'b1;
                  w_if_rdata = bus.mem_rdata;
               end
            end
         end

         ST_RESP: w_state = ST_IDLE;

         default: w_state = ST_IDLE;
      endcase
   end

   assign bus.if_ack    = r_if_ack;
   assign bus.dm_ack    = r_dm_ack;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.dm_rdata  = r_dm_rdata;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.owner     = r_owner;
   assign bus.busy      = (r_state != ST_IDLE);
   // combinational stalls for the hazard unit
   assign bus.stall_f   = bus.if_req & ~r_if_ack;
   assign bus.stall_m   = bus.dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model with exact read latency, ack
// scoreboard (port, data, cycle) plus direct checks of mem_* and stalls.
module tb_mem_port_arbiter;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned MEM_LAT = 2;

   logic clk;
   logic reset;
   int   cyc          = 0;
   int   n_compared   = 0;
   int   n_mismatched = 0;

   mem_port_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   mem_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // memory model: read data valid only in the last enabled cycle
   logic [31:0] mem_arr [256];
   bit          mem_wr  [256];
   int          en_cnt = 0;

   function automatic logic [31:0] init_val(input logic [7:0] a);
      if (a == 8'h10) return 32'hE3A01005;
      return {8'h5A, 8'h00, a, ~a};
   endfunction

   function automatic logic [31:0] mem_val(input logic [7:0] a);
      return mem_wr[a] ? mem_arr[a] : init_val(a);
   endfunction

   always @(posedge clk) begin
      en_cnt <= bus.mem_en ? en_cnt + 1 : 0;
      if (bus.mem_en && bus.mem_we) begin
         mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
         mem_wr[bus.mem_addr[7:0]]  <= 1'b1;
      end
   end

   assign bus.mem_rdata = (bus.mem_en && !bus.mem_we && (en_cnt == int'(MEM_LAT) - 1))
                          ? mem_val(bus.mem_addr[7:0]) : 32'hBAD0BAD0;

   // scoreboard of expected acks
   typedef struct {
      bit          dm;
      logic [31:0] data;
      int          at;
   } exp_t;
   exp_t sb_q[$];
   bit   hold_reqs = 1'b0;
   logic s_stall_f;
   logic s_stall_m;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_exp(input bit dm, input logic [31:0] data, input int at);
      exp_t e;
      e.dm   = dm;
      e.data = data;
      e.at   = at;
      sb_q.push_back(e);
   endtask

   // advance to the next falling edge, score any ack, release acked requests
   task automatic tick();
      exp_t        e;
      logic [31:0] obs;
      @(negedge clk);
      s_stall_f = bus.stall_f;
      s_stall_m = bus.stall_m;
      if (bus.if_ack || bus.dm_ack) begin
         check_eq("dual_ack", 64'(bus.if_ack & bus.dm_ack), 64'd0);
         check_eq("ack_pending", 64'(sb_q.size() > 0), 64'd1);
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = e.dm ? bus.dm_rdata : bus.if_rdata;
            check_eq("ack_port", 64'(bus.dm_ack), 64'(e.dm));
            check_eq("ack_cycle", 64'(cyc), 64'(e.at));
            check_eq("ack_rdata", 64'(obs), 64'(e.data));
         end
         if (!hold_reqs) begin
            if (bus.if_ack) bus.if_req = 1'b0;
            if (bus.dm_ack) begin
               bus.dm_req = 1'b0;
               bus.dm_we  = 1'b0;
            end
         end
      end
   endtask

   initial begin
      int t;
      reset        = 1'b0;
      bus.if_req   = 1'b1;
      bus.if_addr  = 32'h1C;
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b0;
      bus.dm_addr  = 32'h30;
      bus.dm_wdata = 32'h0;

      // reset held with both requests pending
      tick();
      tick();
      check_eq("rst_ctrl", 64'({bus.if_ack, bus.dm_ack, bus.busy, bus.mem_en, bus.mem_we, bus.owner}), 64'd0);
      check_eq("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check_eq("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      check_eq("rst_rdata", 64'({bus.if_rdata, bus.dm_rdata}), 64'd0);

      // release: DM first, then IF
      reset = 1'b1;
      t = cyc;
      push_exp(1'b1, init_val(8'h30), t + 3);
      push_exp(1'b0, init_val(8'h1C), t + 7);
      tick();
      check_eq("rel_owner", 64'(bus.owner), 64'd1);
      check_eq("rel_busy", 64'(bus.busy), 64'd1);
      check_eq("rel_mem_addr", 64'(bus.mem_addr), 64'h30);
      repeat (6) tick();
      tick();
      check_eq("rel_idle", 64'(bus.busy), 64'd0);

      // lone IF read
      t = cyc;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h10;
      push_exp(1'b0, 32'hE3A01005, t + 3);
      #1;
      check_eq("if_stall_t0", 64'(bus.stall_f), 64'd1);
      tick();
      check_eq("if_mem_t1", 64'({bus.mem_en, bus.mem_we, bus.mem_addr}), {31'd0, 1'b1, 1'b0, 32'h10});
      check_eq("if_stall_t1", 64'(s_stall_f), 64'd1);
      tick();
      check_eq("if_mem_t2", 64'({bus.mem_en, bus.mem_addr}), {31'd0, 1'b1, 32'h10});
      check_eq("if_stall_t2", 64'(s_stall_f), 64'd1);
      tick();
      check_eq("if_stall_t3", 64'(s_stall_f), 64'd0);
      check_eq("if_rdata_t3", 64'(bus.if_rdata), 64'hE3A01005);
      check_eq("if_mem_en_t3", 64'(bus.mem_en), 64'd0);
      tick();
      check_eq("if_idle_t4", 64'(bus.busy), 64'd0);

      // IF and DM reads together
      t = cyc;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h14;
      bus.dm_req  = 1'b1;
      bus.dm_addr = 32'h40;
      push_exp(1'b1, init_val(8'h40), t + 3);
      push_exp(1'b0, init_val(8'h14), t + 7);
      for (int k = 1; k <= 7; k++) begin
         tick();
         check_eq($sformatf("both_stall_f_%0d", k), 64'(s_stall_f), 64'(k < 7));
         if (k == 4) check_eq("both_idle_t4", 64'(bus.busy), 64'd0);
      end
      tick();

      // DM write leaves dm_rdata alone
      t = cyc;
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b1;
      bus.dm_addr  = 32'h20;
      bus.dm_wdata = 32'hDEADBEEF;
      push_exp(1'b1, init_val(8'h40), t + 3);
      for (int k = 1; k <= 2; k++) begin
         tick();
         check_eq($sformatf("wr_ctrl_%0d", k), 64'({bus.mem_en, bus.mem_we, bus.mem_addr}), {30'd0, 2'b11, 32'h20});
         check_eq($sformatf("wr_wdata_%0d", k), 64'(bus.mem_wdata), 64'hDEADBEEF);
      end
      tick();
      check_eq("wr_we_resp", 64'(bus.mem_we), 64'd0);
      tick();

      // starvation: both held, DM, DM, IF repeating
      t = cyc;
      hold_reqs   = 1'b1;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h18;
      bus.dm_req  = 1'b1;
      bus.dm_we   = 1'b0;
      bus.dm_addr = 32'h20;
      for (int k = 0; k < 6; k++)
         push_exp(k % 3 != 2, (k % 3 != 2) ? 32'hDEADBEEF : init_val(8'h18), t + 3 + 4 * k);
      for (int k = 1; k <= 23; k++) begin
         tick();
         if (k % 4 == 1)
            check_eq($sformatf("starve_owner_%0d", k / 4), 64'(bus.owner), 64'((k / 4) % 3 != 2));
      end
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      hold_reqs  = 1'b0;
      tick();
      check_eq("starve_idle", 64'(bus.busy), 64'd0);

      // reset during a DM read abandons it
      bus.dm_req  = 1'b1;
      bus.dm_addr = 32'h44;
      tick();
      check_eq("abort_en_t1", 64'(bus.mem_en), 64'd1);
      reset      = 1'b0;
      bus.dm_req = 1'b0;
      tick();
      check_eq("abort_ctrl_t2", 64'({bus.mem_en, bus.busy, bus.owner, bus.dm_ack}), 64'd0);
      check_eq("abort_rdata_t2", 64'(bus.dm_rdata), 64'd0);
      reset = 1'b1;
      repeat (6) tick();

      // normal read after recovery
      t = cyc;
      bus.dm_req  = 1'b1;
      bus.dm_addr = 32'h48;
      push_exp(1'b1, init_val(8'h48), t + 3);
      repeat (4) tick();
      check_eq("post_abort_idle", 64'(bus.busy), 64'd0);

      check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the pipeline's fetch-stage instruction port (IF) and memory-stage data port (DM).
- Sits between the pipeline datapath and the memory macro.
- Serialises accesses, sequences the memory wait states, and returns per-requester ack/rdata plus stall outputs for the hazard logic.
- DM has priority, bounded by an anti-starvation rule for IF.

Parameters:
WIDTH, 32, data width of all read/write data buses
ADDR_W, 32, address width
MEM_LAT, 2, memory read latency in cycles from first enable cycle to valid mem_rdata (legal >= 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
if_req  input  1  fetch read request, held until if_ack
if_addr  input  ADDR_W  fetch address, stable while if_req
if_ack  output  1  one-cycle pulse: fetch access complete, if_rdata valid
if_rdata  output  WIDTH  registered fetch read data
dm_req  input  1  data request, held until dm_ack
dm_we  input  1  1 = write, 0 = read; stable while dm_req
dm_addr  input  ADDR_W  data address
dm_wdata  input  WIDTH  write data
dm_ack  output  1  one-cycle pulse: data access complete
dm_rdata  output  WIDTH  registered data read data
mem_en  output  1  memory enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  WIDTH  memory write data
mem_rdata  input  WIDTH  memory read data
stall_f  output  1  if_req & ~if_ack (combinational)
stall_m  output  1  dm_req & ~dm_ack (combinational)
busy  output  1  state != IDLE
owner  output  1  current/last grant: 0 = IF, 1 = DM

Behaviour:
- Reset (reset == 0 at clk edge), regardless of state:
  - state = IDLE; all outputs 0, including if_rdata, dm_rdata, owner, mem_* buses.
  - wait counter = 0; starve counter = 0.
  - An in-flight access is abandoned: no ack is ever issued for it.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise select a winner:
    - DM wins if dm_req and starve_cnt < 2.
    - Else IF wins if if_req.
    - Else DM wins if dm_req.
  - On a grant: register owner, addr, we (IF always 0), wdata into the mem_* output registers; clear wait counter; go to ACCESS.
- ACCESS:
  - mem_en = 1 for exactly MEM_LAT cycles; mem_we = latched we for those cycles.
  - mem_addr and mem_wdata are held constant throughout.
  - Counter increments each cycle. At count == MEM_LAT-1:
    - Reads: capture mem_rdata into the owner's rdata register.
    - Go to RESP.
- RESP:
  - Owner's ack = 1 for one cycle; mem_en = 0, mem_we = 0; always return to IDLE.
  - Writes leave dm_rdata unchanged.
- Latency: request sampled in IDLE at cycle t → ACCESS t+1..t+MEM_LAT → ack at t+MEM_LAT+1. Minimum access period is MEM_LAT+2 cycles.
- Anti-starvation counter (2-bit, saturating), updated on every grant:
  - DM granted while if_req = 1: starve_cnt + 1.
  - IF granted: cleared to 0.
  - DM granted while if_req = 0: cleared to 0.
  - Result: with both requesting continuously, the grant pattern is DM, DM, IF, DM, DM, IF...
- Request rules:
  - A requester deasserts req in the cycle after its ack. Because RESP always returns to IDLE, a held req is re-evaluated fresh.
  - Dropping req mid-access is a protocol violation. The access still completes and ack still pulses.
- owner holds its last value while in IDLE.
- Simultaneous reset and ack cycle: reset wins; ack = 0.
- Address and data are not modified: no wrap-around, no width conversion.

Test Plan:
- Reset: hold reset=0 for 2 cycles with if_req=dm_req=1 → all outputs 0, busy=0, no mem_en; release → DM granted first.
- IF read alone, MEM_LAT=2, if_addr=0x10 at t, memory returns 0xE3A01005 → mem_en=1 at t+1..t+2 with mem_addr=0x10, if_ack=1 and if_rdata=0xE3A01005 at t+3, stall_f=1 for t..t+2.
- IF and DM reads both asserted at t → dm_ack at t+3, IDLE at t+4, if_ack at t+7; stall_f high t..t+6.
- Write: dm_we=1, dm_addr=0x20, dm_wdata=0xDEADBEEF → mem_we=1 with those values for 2 cycles, dm_ack pulse, dm_rdata unchanged from prior read.
- Starvation: dm_req and if_req held high for 24 cycles → owner sequence DM, DM, IF, DM, DM, IF; if_ack occurs every 12 cycles.
- Reset mid-ACCESS (reset=0 at t+1 of a DM read) → mem_en=0 at t+2, no dm_ack ever; next request after release completes normally.
